// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one command at a time to an external combinational
// 3-bit ALU, writes the result into a 4 x 3-bit register file and returns
// the result plus flags on a valid/ready response channel. Load-immediate
// commands bypass the ALU entirely.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ld,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic [2:0] cmd_imm,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [2:0] alu_sel,
    output logic       alu_req,
    input  logic [2:0] alu_f,
    input  logic       alu_v,
    input  logic       alu_n,
    input  logic       alu_c,
    input  logic       alu_z,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_f,
    output logic [3:0] rsp_flags,
    input  logic [1:0] dbg_addr,
    output logic [2:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t     state_q, state_d;

    logic [2:0] rf_q [4];

    logic [2:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [1:0] rs1_q, rs1_d;
    logic [1:0] rs2_q, rs2_d;

    logic [2:0] rsp_f_q, rsp_f_d;
    logic [3:0] rsp_flags_q, rsp_flags_d;

    logic [2:0] alu_a_q, alu_b_q, alu_sel_q;

    logic       rf_we;
    logic [1:0] rf_wa;
    logic [2:0] rf_wd;

    logic       in_issue;
    logic [2:0] opnd_a, opnd_b;

    // Operands come straight from the register file during ISSUE, so they
    // always see the pre-write values even when rd aliases rs1/rs2.
    assign in_issue  = (state_q == S_ISSUE);
    assign opnd_a    = rf_q[rs1_q];
    assign opnd_b    = rf_q[rs2_q];

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign alu_req   = in_issue;
    assign alu_a     = in_issue ? opnd_a : alu_a_q;
    assign alu_b     = in_issue ? opnd_b : alu_b_q;
    assign alu_sel   = in_issue ? op_q   : alu_sel_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_flags = rsp_flags_q;
    assign dbg_data  = rf_q[dbg_addr];

    // Next-state, command latch, register-file write and response payload.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rsp_f_d     = rsp_f_q;
        rsp_flags_d = rsp_flags_q;
        rf_we       = 1'b0;
        rf_wa       = rd_q;
        rf_wd       = alu_f;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ld) begin
                        rf_we       = 1'b1;
                        rf_wa       = cmd_rd;
                        rf_wd       = cmd_imm;
                        rsp_f_d     = cmd_imm;
                        rsp_flags_d = {1'b0, cmd_imm[2], 1'b0, (cmd_imm == 3'b000)};
                        state_d     = S_RESP;
                    end else begin
                        op_d    = cmd_op;
                        rd_d    = cmd_rd;
                        rs1_d   = cmd_rs1;
                        rs2_d   = cmd_rs2;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                rf_we       = 1'b1;
                rf_wa       = rd_q;
                rf_wd       = alu_f;
                rsp_f_d     = alu_f;
                rsp_flags_d = {alu_v, alu_n, alu_c, alu_z};
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched command fields and response payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rsp_f_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rsp_f_q     <= rsp_f_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    // Register file: single write port, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Captures the operands driven during ISSUE so the ALU inputs hold
    // their last values in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
        end else if (in_issue) begin
            alu_a_q   <= opnd_a;
            alu_b_q   <= opnd_b;
            alu_sel_q <= op_q;
        end
    end

endmodule
